// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: FSM states, ALU encodings,
// HALT opcode and instruction field positions.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ALU_AND = 2'b00,
      ALU_OR  = 2'b01,
      ALU_XOR = 2'b10,
      ALU_NOT = 2'b11
   } alu_op_t;

   localparam logic [7:0] HALT_INSTR = 8'h00;

   localparam int OP_LSB = 6;
   localparam int OP_W   = 2;
   localparam int RD_LSB = 3;
   localparam int RS_LSB = 0;

   function automatic alu_op_t decode_op(input logic [1:0] op_field);
      alu_op_t op;
      case (op_field)
         2'b00:   op = ALU_AND;
         2'b01:   op = ALU_OR;
         2'b10:   op = ALU_XOR;
         2'b11:   op = ALU_NOT;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits an instruction word into
// register fields and ALU operation, and flags the all-zero HALT word.
module instr_decode
   import cpu_pkg::*;
#(
   parameter int DW    = 8,
   parameter int RF_AW = 3
) (
   input  logic [DW-1:0]    ir,
   output logic [RF_AW-1:0] rd,
   output logic [RF_AW-1:0] rs,
   output alu_op_t          alu_op,
   output logic             is_halt
);

   assign rd      = ir[RD_LSB +: RF_AW];
   assign rs      = ir[RS_LSB +: RF_AW];
   assign alu_op  = decode_op(ir[OP_LSB +: OP_W]);
   // 8'h00 would otherwise decode as AND r0,r0
   assign is_halt = (ir == DW'(HALT_INSTR));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, write back,
// with a sticky HALT state that only reset can clear.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int IMEM_AW = 4,
   parameter int DW      = 8,
   parameter int RF_AW   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [DW-1:0]      imem_data,
   output logic [RF_AW-1:0]   rf_ra,
   output logic [RF_AW-1:0]   rf_rb,
   output logic [1:0]         alu_op,
   output logic               rf_we,
   output logic [RF_AW-1:0]   rf_wa,
   output logic [IMEM_AW-1:0] pc,
   output logic               halted
);

   localparam logic [IMEM_AW-1:0] PC_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};

   state_t             state_r;
   state_t             state_s;
   logic [DW-1:0]      ir_r;
   logic [DW-1:0]      ir_s;
   logic [IMEM_AW-1:0] pc_r;
   logic [IMEM_AW-1:0] pc_s;
   logic [RF_AW-1:0]   dec_rd_s;
   logic [RF_AW-1:0]   dec_rs_s;
   alu_op_t            dec_op_s;
   logic               dec_halt_s;

   // Instruction register load: capture the fetched word only while fetching
   always_comb begin
      ir_s = ir_r;
      if ((state_r == ST_FETCH) && imem_ack) begin
         ir_s = imem_data;
      end else begin
         ir_s = ir_r;
      end
   end

   // Decoding the next IR value lets the register-file outputs be registered
   // yet already valid in the DECODE cycle.
   instr_decode #(
      .DW    (DW),
      .RF_AW (RF_AW)
   ) u_instr_decode (
      .ir      (ir_s),
      .rd      (dec_rd_s),
      .rs      (dec_rs_s),
      .alu_op  (dec_op_s),
      .is_halt (dec_halt_s)
   );

   // Next-state and PC update
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      case (state_r)
         ST_IDLE: begin
            if (run) state_s = ST_FETCH;
            else     state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (imem_ack) state_s = ST_DECODE;
            else          state_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (dec_halt_s) state_s = ST_HALT;
            else            state_s = ST_EXEC;
         end
         ST_EXEC: begin
            state_s = ST_WB;
         end
         ST_WB: begin
            pc_s = pc_r + PC_ONE;
            if (run) state_s = ST_FETCH;
            else     state_s = ST_IDLE;
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, IR, PC and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         ir_r     <= {DW{1'b0}};
         pc_r     <= {IMEM_AW{1'b0}};
         imem_req <= 1'b0;
         rf_we    <= 1'b0;
         halted   <= 1'b0;
         rf_ra    <= {RF_AW{1'b0}};
         rf_rb    <= {RF_AW{1'b0}};
         rf_wa    <= {RF_AW{1'b0}};
         alu_op   <= 2'b00;
      end else begin
         state_r  <= state_s;
         ir_r     <= ir_s;
         pc_r     <= pc_s;
         imem_req <= (state_s == ST_FETCH);
         rf_we    <= (state_s == ST_WB);
         halted   <= (state_s == ST_HALT);
         rf_ra    <= dec_rd_s;
         rf_rb    <= dec_rs_s;
         rf_wa    <= dec_rd_s;
         alu_op   <= dec_op_s;
      end
   end

   assign pc        = pc_r;
   assign imem_addr = pc_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a randomized
// phase, all checked every cycle against a stage-count reference model.
module tb_cpu_sequencer;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          imem_ack;
   logic [DW-1:0] imem_data;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [RW-1:0] rf_ra;
   logic [RW-1:0] rf_rb;
   logic [1:0]    alu_op;
   logic          rf_we;
   logic [RW-1:0] rf_wa;
   logic [AW-1:0] pc;
   logic          halted;

   always #5 clk = ~clk;

   cpu_sequencer #(.IMEM_AW(AW), .DW(DW), .RF_AW(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .rf_ra     (rf_ra),
      .rf_rb     (rf_rb),
      .alu_op    (alu_op),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .pc        (pc),
      .halted    (halted)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] imem [16];
   bit auto_ack;
   bit spurious;
   int min_delay;
   int max_delay;
   int cur_delay;
   int req_age;

   // Reference model: m_stage counts cycles since the fetch was accepted
   // (1 decode, 2 execute, 3 write-back); 0 means no instruction in flight.
   bit         m_req;
   bit         m_halt;
   int         m_stage;
   int         m_pc;
   logic [7:0] m_ir;
   typedef struct {int wa; int ra; int rb; int op;} wr_t;
   wr_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_delay(input int lo, input int hi);
      min_delay = lo;
      max_delay = hi;
      cur_delay = int'($urandom_range(hi, lo));
      req_age   = 0;
   endtask

   task automatic model_step();
      if (rst) begin
         m_req = 1'b0; m_halt = 1'b0; m_stage = 0; m_pc = 0; m_ir = 8'h00;
         sb.delete();
      end else if (m_halt) begin
         m_halt = 1'b1;
      end else if (m_stage == 1) begin
         if (m_ir == 8'h00) begin m_halt = 1'b1; m_stage = 0; end
         else m_stage = 2;
      end else if (m_stage == 2) begin
         m_stage = 3;
      end else if (m_stage == 3) begin
         m_pc = (m_pc + 1) % 16;
         m_stage = 0;
         m_req = run;
      end else if (m_req) begin
         if (imem_ack) begin
            m_ir = imem_data;
            m_stage = 1;
            m_req = 1'b0;
            if (imem_data != 8'h00)
               sb.push_back('{int'((imem_data >> 3) & 8'h07), int'((imem_data >> 3) & 8'h07),
                              int'(imem_data & 8'h07), int'(imem_data >> 6)});
         end
      end else begin
         m_req = run;
      end
   endtask

   task automatic compare();
      wr_t e;
      chk("imem_req", 32'(imem_req), 32'(m_req));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("rf_we", 32'(rf_we), 32'(m_stage == 3));
      if (m_stage != 0) begin
         chk("rf_ra", 32'(rf_ra), 32'((m_ir >> 3) & 8'h07));
         chk("rf_rb", 32'(rf_rb), 32'(m_ir & 8'h07));
         chk("alu_op", 32'(alu_op), 32'(m_ir >> 6));
      end
      if (m_halt) begin
         chk("halt_fields", 32'({rf_ra, rf_rb, rf_wa, alu_op}), 32'(0));
      end
      if (rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_write: got write to r%0d expected none", rf_wa);
         end else begin
            e = sb.pop_front();
            chk("sb_wa", 32'(rf_wa), 32'(e.wa));
            chk("sb_ra", 32'(rf_ra), 32'(e.ra));
            chk("sb_rb", 32'(rf_rb), 32'(e.rb));
            chk("sb_op", 32'(alu_op), 32'(e.op));
         end
      end
   endtask

   task automatic respond();
      if (!auto_ack) return;
      imem_ack  = 1'b0;
      imem_data = 8'($urandom);
      if (imem_req === 1'b1) begin
         if (req_age >= cur_delay) begin
            imem_ack  = 1'b1;
            imem_data = imem[imem_addr];
            req_age   = 0;
            cur_delay = int'($urandom_range(max_delay, min_delay));
         end else begin
            req_age++;
         end
      end else begin
         req_age = 0;
         if (spurious && ($urandom_range(0, 3) == 0)) imem_ack = 1'b1;
      end
   endtask

   task automatic cycle();
      respond();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
   endtask

   task automatic fill_nonzero();
      for (int i = 0; i < 16; i++) imem[i] = 8'($urandom_range(1, 255));
   endtask

   initial begin
      int         nw;
      int         nreq;
      logic [10:0] w [4];

      rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
      auto_ack = 1'b1; spurious = 1'b0;
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
      @(negedge clk);

      // A: single XOR r1,r2 with same-cycle ack
      imem[0] = 8'b10_001_010;
      set_delay(0, 0);
      do_reset();
      chk("a_rst_req", 32'(imem_req), 32'd0);
      chk("a_rst_pc", 32'(pc), 32'd0);
      chk("a_rst_halted", 32'(halted), 32'd0);
      chk("a_rst_we", 32'(rf_we), 32'd0);
      chk("a_rst_fields", 32'({rf_ra, rf_rb, rf_wa, alu_op}), 32'd0);
      run = 1'b1;
      cycle();
      chk("a_fetch_req", 32'(imem_req), 32'd1);
      repeat (2) cycle();
      chk("a_no_early_we", 32'(rf_we), 32'd0);
      cycle();
      chk("a_we", 32'(rf_we), 32'd1);
      chk("a_wa", 32'(rf_wa), 32'd1);
      chk("a_ra", 32'(rf_ra), 32'd1);
      chk("a_rb", 32'(rf_rb), 32'd2);
      chk("a_op", 32'(alu_op), 32'd2);
      cycle();
      chk("a_pc", 32'(pc), 32'd1);

      // B: ack delayed five cycles
      imem[0] = 8'h5C;
      set_delay(5, 5);
      do_reset();
      run = 1'b1;
      nw = 0; nreq = 0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (imem_req === 1'b1 && pc == 4'd0) nreq++;
         if (rf_we === 1'b1) nw++;
         if (pc == 4'd1) break;
      end
      chk("b_req_cycles", 32'(nreq), 32'd6);
      chk("b_writes", 32'(nw), 32'd1);

      // C: OR, NOT, HALT program; halt is sticky until reset
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
      imem[0] = 8'h4B; imem[1] = 8'hC1; imem[2] = 8'h00;
      set_delay(0, 2);
      spurious = 1'b1;
      do_reset();
      run = 1'b1;
      nw = 0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (rf_we === 1'b1 && nw < 4) begin
            w[nw] = {rf_wa, rf_ra, rf_rb, alu_op};
            nw++;
         end
         if (halted === 1'b1) break;
      end
      chk("c_writes", 32'(nw), 32'd2);
      chk("c_w0", 32'(w[0]), 32'({3'd1, 3'd1, 3'd3, 2'b01}));
      chk("c_w1", 32'(w[1]), 32'({3'd0, 3'd0, 3'd1, 2'b11}));
      chk("c_halted", 32'(halted), 32'd1);
      chk("c_pc", 32'(pc), 32'd2);
      for (int i = 0; i < 12; i++) begin
         run = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("c_still_halted", 32'(halted), 32'd1);
      chk("c_halt_req", 32'(imem_req), 32'd0);
      chk("c_halt_pc", 32'(pc), 32'd2);
      do_reset();
      chk("c_rst_halted", 32'(halted), 32'd0);
      chk("c_rst_pc", 32'(pc), 32'd0);
      spurious = 1'b0;

      // D: PC wraps from 15 to 0
      fill_nonzero();
      set_delay(0, 0);
      do_reset();
      run = 1'b1;
      nw = 0;
      for (int i = 0; i < 300 && nw < 16; i++) begin
         cycle();
         if (rf_we === 1'b1) begin
            nw++;
            if (nw == 16) chk("d_pc15", 32'(pc), 32'd15);
         end
      end
      chk("d_writes", 32'(nw), 32'd16);
      cycle();
      chk("d_pc_wrap", 32'(pc), 32'd0);
      chk("d_addr_wrap", 32'(imem_addr), 32'd0);

      // E: run dropped during EXEC retires the instruction, then parks
      do_reset();
      run = 1'b1;
      repeat (3) cycle();
      chk("e_exec_we", 32'(rf_we), 32'd0);
      run = 1'b0;
      cycle();
      chk("e_wb_we", 32'(rf_we), 32'd1);
      nw = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("e_idle_req", 32'(imem_req), 32'd0);
         if (rf_we === 1'b1) nw++;
      end
      chk("e_extra_we", 32'(nw), 32'd0);
      chk("e_pc", 32'(pc), 32'd1);
      run = 1'b1;
      cycle();
      chk("e_refetch_req", 32'(imem_req), 32'd1);
      chk("e_refetch_addr", 32'(imem_addr), 32'd1);

      // F: reset coincident with ack discards the instruction
      auto_ack = 1'b0;
      imem_ack = 1'b0;
      do_reset();
      run = 1'b1;
      repeat (3) cycle();
      chk("f_req", 32'(imem_req), 32'd1);
      imem_ack = 1'b1; imem_data = 8'h8A; rst = 1'b1;
      cycle();
      imem_ack = 1'b0; rst = 1'b0; run = 1'b0;
      nw = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (rf_we === 1'b1) nw++;
      end
      chk("f_no_write", 32'(nw), 32'd0);
      chk("f_pc", 32'(pc), 32'd0);
      chk("f_req_idle", 32'(imem_req), 32'd0);
      chk("f_halted", 32'(halted), 32'd0);

      // G: randomized run/ack/reset traffic
      for (int i = 0; i < 16; i++)
         imem[i] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      auto_ack = 1'b1;
      spurious = 1'b1;
      set_delay(0, 3);
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 9) == 0) run = ~run;
         if ((halted === 1'b1 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) rst = 1'b1;
         else rst = 1'b0;
         cycle();
      end
      rst = 1'b0;
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
